// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle
// for the iterative divider functional unit.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one trial
// subtraction per clock, MSB first.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q, q_q, dvs_q;
  logic             zero_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dbz_q;

  logic             accept, last, borrow;
  logic [WIDTH:0]   t, d;
  logic [WIDTH-1:0] r_n, q_n;

  assign accept = bus.start & (state != RUN);
  assign last   = zero_q | (cnt == CW'(WIDTH - 1));

  // Trial subtraction: the shifted-out R MSB rides along as bit WIDTH.
  assign t      = {r_q, q_q[WIDTH-1]};
  assign d      = t - {1'b0, dvs_q};
  assign borrow = d[WIDTH];
  assign r_n    = borrow ? t[WIDTH-1:0] : d[WIDTH-1:0];
  assign q_n    = {q_q[WIDTH-2:0], ~borrow};

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: DONE may accept a new start directly.
  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == IDLE: if (bus.start) state_n = RUN;
      state == RUN:  if (last)      state_n = DONE;
      state == DONE: state_n = bus.start ? RUN : IDLE;
      default:       state_n = IDLE;
    endcase
  end

  // Operand capture, iteration and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      zero_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= bus.dividend;
      dvs_q  <= bus.divisor;
      zero_q <= (bus.divisor == '0);
    end else if (state == RUN) begin
      r_q <= r_n;
      q_q <= q_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        quo_q <= zero_q ? '1 : q_n;
        rem_q <= zero_q ? q_q : r_n;
        dbz_q <= zero_q;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider
// against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int dd, input int dv,
                       output int q, output int r,
                       output int z, output int lat);
    if (dv == 0) begin
      q = (1 << W) - 1; r = dd; z = 1; lat = 1;
    end else begin
      q = dd / dv; r = dd % dv; z = 0; lat = W;
    end
  endtask

  // Wait for done from just after the start edge; busy must be high
  // on every sampled cycle before it.
  task automatic wait_done(input bit poke, output int lat,
                           output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (poke && lat == 3) begin
        bus.start = 1'b1; bus.dividend = 50; bus.divisor = 5;
      end else if (poke) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input int dd,
                        input int dv, input bit poke,
                        input bit full);
    int q, r, z, el, lat;
    bit bok;
    model(dd, dv, q, r, z, el);
    bus.start = 1'b1;
    bus.dividend = W'(dd);
    bus.divisor  = W'(dv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(poke, lat, bok);
    bus.start = 1'b0;
    chk({tag, " lat"}, lat, el);
    chk({tag, " quo"}, bus.quotient, q);
    chk({tag, " rem"}, bus.remainder, r);
    chk({tag, " dbz"}, bus.div_by_zero, z);
    if (full) begin
      chk({tag, " busy"}, {31'd0, bok}, 1);
      chk({tag, " busy@done"}, bus.busy, 0);
    end
    if (z == 0 && dv != 0) begin
      chk({tag, " inv"}, bus.quotient * dv + bus.remainder, dd);
      chk({tag, " rlt"}, {31'd0, bus.remainder < W'(dv)}, 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, pulses;
    bit bok;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst quo", bus.quotient, 0);
    chk("rst rem", bus.remainder, 0);
    chk("rst dbz", bus.div_by_zero, 0);

    run_op("200/7", 200, 7, 0, 1);
    run_op("255/1", 255, 1, 0, 1);
    run_op("5/9", 5, 9, 0, 1);
    run_op("0/3", 0, 3, 0, 1);
    run_op("255/255", 255, 255, 0, 1);
    run_op("100/0", 100, 0, 0, 1);
    run_op("9/3", 9, 3, 0, 1);

    run_op("ign", 200, 7, 1, 1);
    pulses = 0;
    repeat (12) begin
      if (bus.done) pulses++;
      @(posedge clk); #1;
    end
    chk("ign extra done", pulses, 0);

    bus.start = 1'b1; bus.dividend = 200; bus.divisor = 7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", bus.busy, 0);
    chk("arst done", bus.done, 0);
    chk("arst quo", bus.quotient, 0);
    chk("arst rem", bus.remainder, 0);
    chk("arst dbz", bus.div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("stale done", pulses, 0);
    run_op("81/9", 81, 9, 0, 1);

    bus.start = 1'b1; bus.dividend = 200; bus.divisor = 7;
    @(posedge clk); #1;
    wait_done(0, lat, bok);
    chk("b2b1 lat", lat, W);
    chk("b2b1 quo", bus.quotient, 28);
    chk("b2b1 rem", bus.remainder, 4);
    bus.dividend = 13; bus.divisor = 2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(0, lat, bok);
    chk("b2b2 lat", lat, W);
    chk("b2b2 quo", bus.quotient, 6);
    chk("b2b2 rem", bus.remainder, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      int dd, dv;
      dd = int'($urandom_range(0, 255));
      dv = ($urandom_range(0, 15) == 0) ? 0
           : int'($urandom_range(1, 255));
      run_op("rnd", dd, dv, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
